// File: rtl/sdram_arbiter.sv
// Slot-based SDRAM arbiter: time-multiplexes one SDRAM controller between a CPU
// port and a read-only video port, inserting refresh slots on a fixed interval.
module sdram_arbiter #(
  parameter int SLOT_LEN         = 8,
  parameter int REFRESH_INTERVAL = 500,
  parameter int STARTUP_CYCLES   = 512
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [24:0] cpu_addr,
  input  logic [7:0]  cpu_din,
  output logic [7:0]  cpu_dout,
  output logic        cpu_ack,
  input  logic        vid_req,
  input  logic [24:0] vid_addr,
  output logic [7:0]  vid_dout,
  output logic        vid_ack,
  output logic        sd_ce,
  output logic        sd_we,
  output logic [24:0] sd_addr,
  output logic [7:0]  sd_din,
  output logic        sd_refresh,
  input  logic [7:0]  sd_dout,
  output logic        ready
);

  localparam int SW = $clog2(SLOT_LEN);
  localparam int TW = $clog2(REFRESH_INTERVAL);
  localparam int UW = $clog2(STARTUP_CYCLES + 1);

  localparam logic [SW-1:0] SLOT_FIRST   = SW'(0);
  localparam logic [SW-1:0] SLOT_LAST    = SW'(SLOT_LEN - 1);
  localparam logic [SW-1:0] STROBE_END   = SW'(SLOT_LEN / 2);
  localparam logic [TW-1:0] TIMER_LAST   = TW'(REFRESH_INTERVAL - 1);
  localparam logic [UW-1:0] STARTUP_LAST = UW'(STARTUP_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REFRESH = 2'd1,
    S_CPU     = 2'd2,
    S_VID     = 2'd3
  } slot_state_t;

  logic [SW-1:0] slot_cnt_r;
  logic [UW-1:0] startup_cnt_r;
  logic [TW-1:0] refresh_timer_r;
  logic          refresh_pending_r;
  logic          favour_vid_r;
  slot_state_t   state_r;

  slot_state_t   next_state_s;
  logic          timer_expire_s;

  // Owner of the next slot; only meaningful when slot_cnt_r is at the boundary.
  always_comb begin
    next_state_s = S_IDLE;
    if (!ready) begin
      next_state_s = S_IDLE;
    end else if (refresh_pending_r) begin
      next_state_s = S_REFRESH;
    end else if (cpu_req && vid_req) begin
      next_state_s = favour_vid_r ? S_VID : S_CPU;
    end else if (cpu_req) begin
      next_state_s = S_CPU;
    end else if (vid_req) begin
      next_state_s = S_VID;
    end else begin
      next_state_s = S_IDLE;
    end
  end

  // Refresh timer wrap point.
  always_comb begin
    timer_expire_s = 1'b0;
    if (ready && (refresh_timer_r == TIMER_LAST)) begin
      timer_expire_s = 1'b1;
    end else begin
      timer_expire_s = 1'b0;
    end
  end

  // Slot scheduler, counters and all registered SDRAM/client outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      slot_cnt_r        <= SLOT_FIRST;
      startup_cnt_r     <= {UW{1'b0}};
      refresh_timer_r   <= {TW{1'b0}};
      refresh_pending_r <= 1'b0;
      favour_vid_r      <= 1'b1;
      state_r           <= S_IDLE;
      sd_ce             <= 1'b0;
      sd_refresh        <= 1'b0;
      sd_we             <= 1'b0;
      sd_addr           <= 25'd0;
      sd_din            <= 8'd0;
      cpu_dout          <= 8'd0;
      vid_dout          <= 8'd0;
      cpu_ack           <= 1'b0;
      vid_ack           <= 1'b0;
      ready             <= 1'b0;
    end else begin
      slot_cnt_r <= (slot_cnt_r == SLOT_LAST) ? SLOT_FIRST : slot_cnt_r + SW'(1);

      if (!ready) begin
        startup_cnt_r <= startup_cnt_r + UW'(1);
        ready         <= (startup_cnt_r == STARTUP_LAST);
      end

      if (ready) begin
        refresh_timer_r <= timer_expire_s ? {TW{1'b0}} : refresh_timer_r + TW'(1);
      end

      // A fresh expiry wins over the clear so a back-to-back interval is not lost.
      if (timer_expire_s) begin
        refresh_pending_r <= 1'b1;
      end else if ((slot_cnt_r == SLOT_FIRST) && (next_state_s == S_REFRESH)) begin
        refresh_pending_r <= 1'b0;
      end

      cpu_ack <= 1'b0;
      vid_ack <= 1'b0;

      if (slot_cnt_r == SLOT_FIRST) begin
        state_r    <= next_state_s;
        sd_ce      <= (next_state_s == S_CPU) || (next_state_s == S_VID);
        sd_refresh <= (next_state_s == S_REFRESH);
        case (next_state_s)
          S_CPU: begin
            sd_addr      <= cpu_addr;
            sd_we        <= cpu_we;
            sd_din       <= cpu_din;
            favour_vid_r <= 1'b1;
          end
          S_VID: begin
            sd_addr      <= vid_addr;
            sd_we        <= 1'b0;
            favour_vid_r <= 1'b0;
          end
          S_REFRESH: begin
            sd_we <= 1'b0;
          end
          default: begin
          end
        endcase
      end else if (slot_cnt_r == STROBE_END) begin
        sd_ce      <= 1'b0;
        sd_refresh <= 1'b0;
      end

      if (slot_cnt_r == SLOT_LAST) begin
        case (state_r)
          S_CPU: begin
            cpu_ack  <= 1'b1;
            cpu_dout <= sd_dout;
          end
          S_VID: begin
            vid_ack  <= 1'b1;
            vid_dout <= sd_dout;
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: doc/sdram_arbiter.md
SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 Parameters: SLOT_LEN=8 (clocks per access slot); REFRESH_INTERVAL=500 (clocks between refreshes, 7.8us at 64MHz); STARTUP_CYCLES=512 (clocks before first grant).
REQ-002 clk  in  1  controller clock, same clock as the downstream SDRAM controller.
REQ-003 reset  in  1  synchronous, active-high.
REQ-004 cpu_req  in  1  level request; cpu_we  in  1  write; cpu_addr  in  25  byte address; cpu_din  in  8  write data.
REQ-005 cpu_dout  out  8  read data; cpu_ack  out  1  one-clock completion pulse.
REQ-006 vid_req  in  1  read-only request; vid_addr  in  25; vid_dout  out  8; vid_ack  out  1.
REQ-007 sd_ce  out  1; sd_we  out  1; sd_addr  out  25; sd_din  out  8; sd_refresh  out  1. These are the controller's ce/we/addr/din/refresh inputs.
REQ-008 sd_dout  in  8  controller read data.
REQ-009 ready  out  1  high once STARTUP_CYCLES have elapsed.

Function
REQ-010 Free-running slot counter slot_cnt 0..SLOT_LEN-1 shall wrap to 0 after SLOT_LEN-1; all scheduling decisions occur only at slot_cnt==0.
REQ-011 Startup counter shall count from reset to STARTUP_CYCLES; until then no slot shall be granted and ready=0.
REQ-012 Slot states: IDLE, REFRESH, CPU, VID; state is chosen at slot_cnt==0 and held for the whole slot.
REQ-013 Priority at slot_cnt==0: refresh_pending > client; between clients, only requester wins; if both request, the client not granted last time wins (round-robin toggle, initial favour VID).
REQ-014 Refresh timer shall count every clock after ready; at REFRESH_INTERVAL-1 it shall reload to 0 and set refresh_pending; a REFRESH grant shall clear refresh_pending.
REQ-015 If the timer expires while refresh_pending is already set, pending shall stay set (no queueing beyond one).
REQ-016 A request arriving at or after slot_cnt==1 shall wait for the next slot boundary.
REQ-017 On grant, addr/we/din shall be latched into sd_addr/sd_we/sd_din (VID: sd_we=0, sd_din unchanged) and held for the whole slot.
REQ-018 sd_ce (CPU/VID slots) or sd_refresh (REFRESH slot) shall be registered high for slot cycles 0..3 and low for cycles 4..7; sd_ce and sd_refresh shall never be high together.
REQ-019 Read data: sd_dout shall be sampled at slot_cnt==SLOT_LEN-1 into cpu_dout or vid_dout of the granted client; the other client's dout shall hold.
REQ-020 Ack: granted client's ack shall pulse high exactly at slot_cnt==SLOT_LEN-1, together with valid dout; writes ack identically. Latency grant-to-ack = 8 clocks.
REQ-021 Client shall drop req on the clock after ack; req still high at the next slot_cnt==0 is a new access.
REQ-022 Request changes (addr/we/din) after grant shall not affect the slot in progress.
REQ-023 Slot granted but client deasserts req mid-slot: access still completes and ack still issues.

Reset
REQ-024 On reset: slot_cnt=0, startup counter=0, refresh timer=0, refresh_pending=0, state=IDLE, round-robin favours VID; sd_ce=0, sd_refresh=0, sd_we=0, sd_addr=0, sd_din=0, cpu_dout=0, vid_dout=0, cpu_ack=0, vid_ack=0, ready=0.
REQ-025 Reset mid-slot shall abandon the slot with no ack and restart the startup sequence.

Verification
REQ-026 Startup: reset then cpu_req=1 held -> no sd_ce until ready=1 at clock 512; first sd_ce at next slot_cnt==0.
REQ-027 CPU read: cpu_addr=0x0001234, sd_dout=0xA5 -> sd_ce high 4 clocks, sd_addr=0x0001234, sd_we=0; cpu_ack with cpu_dout=0xA5 8 clocks after grant.
REQ-028 Contention: cpu_req and vid_req both held for 4 slots -> grants VID, CPU, VID, CPU; each ack pulse is one clock.
REQ-029 Refresh: run 1000 clocks idle after ready -> sd_refresh pulses exactly twice, 4 clocks wide, never overlapping sd_ce; with cpu_req held, refresh slot delays CPU by one slot.
REQ-030 CPU write: cpu_we=1, cpu_din=0x3C, change cpu_din to 0xFF at slot cycle 2 -> sd_din stays 0x3C all slot; cpu_ack at cycle 7.
REQ-031 Reset at slot cycle 3 of a CPU read -> sd_ce=0 next clock, no cpu_ack, ready=0.
